gate_op_arbiter: RTL and testbench

- Shares one bitwise logic unit (AND / OR / NOT, WIDTH bits) among NUM_REQ requesters.
- Round-robin arbitration. Each transaction follows a fixed accept → execute → respond sequence.
- Sits between requester blocks and the shared gate datapath.
- Returns each result with the winning requester's id.

---
 rtl/gate_op_arbiter.sv | 150 +++++++++++++++
 tb/tb_gate_op_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise AND/OR/NOT unit among NUM_REQ requesters.
// Each transaction runs accept (IDLE) -> execute (EXEC) -> respond (RESP).
module gate_op_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int unsigned NSLOT = 2 ** ID_W;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      last_grant;
    logic [ID_W-1:0]      grant_c;
    logic                 grant_vld_c;
    logic [NSLOT-1:0]     valid_ext_c;
    logic [NUM_REQ-1:0]   req_ready_c;
    logic                 accept_c;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [ID_W-1:0]      id_q;
    logic [WIDTH-1:0]     result_c;
    logic                 err_c;

    assign valid_ext_c = NSLOT'(req_valid);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!grant_vld_c &&
                valid_ext_c[ID_W'((32'(last_grant) + k) % NUM_REQ)]) begin
                grant_vld_c = 1'b1;
                grant_c     = ID_W'((32'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational accept strobe.
    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        accept_c    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld_c) begin
                    req_ready_c = NUM_REQ'(1) << grant_c;
                    accept_c    = 1'b1;
                    state_nxt   = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_c;
    assign busy      = (state != IDLE);

    // Shared gate datapath; reserved opcode yields zero with an error flag.
    always_comb begin
        result_c = '0;
        err_c    = 1'b0;
        case (op_q)
            OP_AND:  result_c = a_q & b_q;
            OP_OR:   result_c = a_q | b_q;
            OP_NOT:  result_c = ~a_q;
            default: err_c    = 1'b1;
        endcase
    end

    // Operand capture on accept and rotation of the priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept_c) begin
            op_q       <= req_op[2*32'(grant_c) +: 2];
            a_q        <= req_a[WIDTH*32'(grant_c) +: WIDTH];
            b_q        <= req_b[WIDTH*32'(grant_c) +: WIDTH];
            id_q       <= grant_c;
            last_grant <= grant_c;
        end
    end

    // Response registers: loaded after execute, held until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= result_c;
            rsp_id    <= id_q;
            rsp_err   <= err_c;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Bench for gate_op_arbiter: transaction-level model plus directed scenarios.
module tb_gate_op_arbiter;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_err;
    logic                     busy;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int grant_q[$];
    int gcyc_q[$];

    gate_op_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Requester that wins when searching upward from last+1 with wraparound.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] gate_result(input int g);
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op = req_op[2*g +: 2];
        a  = req_a[WIDTH*g +: WIDTH];
        b  = req_b[WIDTH*g +: WIDTH];
        if (op == 2'b00) return a & b;
        if (op == 2'b01) return a | b;
        if (op == 2'b10) return ~a;
        return '0;
    endfunction

    function automatic logic gate_err(input int g);
        return req_op[2*g +: 2] == 2'b11;
    endfunction

    // m_busy: a transaction is in flight; m_exec: accepted last edge, result not yet shown.
    logic             m_busy;
    logic             m_exec;
    logic             m_rv;
    logic [WIDTH-1:0] m_rd;
    logic [ID_W-1:0]  m_rid;
    logic             m_rerr;
    int               m_last;
    logic [WIDTH-1:0] p_data;
    logic [ID_W-1:0]  p_id;
    logic             p_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_exec <= 1'b0; m_rv <= 1'b0;
            m_rd <= '0; m_rid <= '0; m_rerr <= 1'b0;
            m_last <= NUM_REQ - 1;
            p_data <= '0; p_id <= '0; p_err <= 1'b0;
        end else if (!m_busy) begin
            if (rr_pick(req_valid, m_last) >= 0) begin
                m_busy <= 1'b1;
                m_exec <= 1'b1;
                m_last <= rr_pick(req_valid, m_last);
                p_id   <= ID_W'(rr_pick(req_valid, m_last));
                p_data <= gate_result(rr_pick(req_valid, m_last));
                p_err  <= gate_err(rr_pick(req_valid, m_last));
            end
        end else if (m_exec) begin
            m_exec <= 1'b0;
            m_rv   <= 1'b1;
            m_rd   <= p_data;
            m_rid  <= p_id;
            m_rerr <= p_err;
        end else if (rsp_ready) begin
            m_rv   <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    function automatic logic [NUM_REQ-1:0] exp_ready();
        if (m_busy || rr_pick(req_valid, m_last) < 0) return '0;
        return NUM_REQ'(1) << rr_pick(req_valid, m_last);
    endfunction

    // Every cycle: compare DUT outputs to the model and log grants.
    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(exp_ready()));
        check("onehot", 32'($countones(req_ready) <= 1), 32'd1);
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("busy", 32'(busy), 32'(m_busy));
        check("rsp_data", 32'(rsp_data), 32'(m_rd));
        check("rsp_id", 32'(rsp_id), 32'(m_rid));
        check("rsp_err", 32'(rsp_err), 32'(m_rerr));
        if (req_ready != 0) begin
            grant_q.push_back($clog2(req_ready));
            gcyc_q.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2]         = op;
        req_a[WIDTH*i +: WIDTH]  = a;
        req_b[WIDTH*i +: WIDTH]  = b;
    endtask

    // Waits (bounded) at negedges for any grant; timeout is a failed comparison.
    task automatic wait_grant(input string nm);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (req_ready != 0) seen = 1'b1;
        end
        check({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_txn(input string nm, input int i, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] xd, input logic xe);
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        rsp_ready    = 1'b1;
        wait_grant(nm);
        check({nm, "_grant"}, 32'(req_ready), 32'(1) << i);
        @(posedge clk); #1 req_valid[i] = 1'b0;
        @(negedge clk);
        check({nm, "_exec_rv"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({nm, "_rv"}, 32'(rsp_valid), 32'd1);
        check({nm, "_data"}, 32'(rsp_data), 32'(xd));
        check({nm, "_id"}, 32'(rsp_id), 32'(i));
        check({nm, "_err"}, 32'(rsp_err), 32'(xe));
        @(posedge clk); #1;
    endtask

    logic [7:0] held;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rv", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic opcodes
        do_txn("and0", 0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);
        do_txn("or2",  2, 2'b01, 8'h0F, 8'hA0, 8'hAF, 1'b0);
        do_txn("not1", 1, 2'b10, 8'h5A, 8'h00, 8'hA5, 1'b0);
        do_txn("rsv3", 3, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b1);

        // Round-robin with all requesters valid
        do_reset();
        @(posedge clk); #1;
        set_req(0, 2'b00, 8'hFF, 8'h11);
        set_req(1, 2'b01, 8'h40, 8'h02);
        set_req(2, 2'b10, 8'h0F, 8'h00);
        set_req(3, 2'b00, 8'hAA, 8'h0F);
        grant_q.delete(); gcyc_q.delete();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int n = 0; n < 40 && grant_q.size() < 5; n++) @(negedge clk);
        @(posedge clk); #1 req_valid = '0;
        check("rr_count", 32'(grant_q.size() >= 5), 32'd1);
        if (grant_q.size() >= 5) begin
            check("rr_g0", 32'(grant_q[0]), 32'd0);
            check("rr_g1", 32'(grant_q[1]), 32'd1);
            check("rr_g2", 32'(grant_q[2]), 32'd2);
            check("rr_g3", 32'(grant_q[3]), 32'd3);
            check("rr_g4", 32'(grant_q[4]), 32'd0);
            for (int k = 1; k < 5; k++)
                check("rr_spacing", 32'(gcyc_q[k] - gcyc_q[k-1]), 32'd3);
        end
        repeat (4) @(posedge clk); #1;

        // Backpressure: requester 1 wins (pointer at 0), requester 2 waits
        rsp_ready = 1'b0;
        set_req(1, 2'b01, 8'h11, 8'h22);
        set_req(2, 2'b00, 8'hC3, 8'h0F);
        req_valid = 4'b0110;
        wait_grant("bp");
        check("bp_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        held = rsp_data;
        check("bp_data", 32'(held), 32'h33);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_rv", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'h33);
            check("bp_hold_id", 32'(rsp_id), 32'd1);
            check("bp_hold_busy", 32'(busy), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_rv", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'h4);
        check("bp_after_rv", 32'(rsp_valid), 32'd0);
        check("bp_retain", 32'(rsp_data), 32'h33);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk); #1;

        // Async reset during EXEC
        set_req(0, 2'b00, 8'h0F, 8'hFF);
        set_req(1, 2'b01, 8'h01, 8'h02);
        set_req(2, 2'b10, 8'h00, 8'h00);
        set_req(3, 2'b00, 8'hF0, 8'hFF);
        req_valid = 4'hF;
        wait_grant("rexec");
        @(posedge clk); #2;
        check("rexec_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rexec_busy", 32'(busy), 32'd0);
        check("rexec_rv", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_grant("rexec_rel");
        check("rexec_first", 32'(req_ready), 32'h1);

        // Async reset during RESP
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            check("rresp_timeout", 32'(seen), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("rresp_rv", 32'(rsp_valid), 32'd0);
        check("rresp_data", 32'(rsp_data), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_grant("rresp_rel");
        check("rresp_first", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
